prog_load_ctrl: RTL and testbench
=================================

PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, instruction-memory word-address width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000, maximum idle cycles between received bytes.
REQ-003 SHALL have port clock  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  in  1  single-cycle request to enter programming mode.
REQ-006 SHALL have port rx_valid  in  1  a received UART byte is presented.
REQ-007 SHALL have port rx_data  in  8  the received byte.
REQ-008 SHALL have port rx_ready  out  1  the block accepts a byte this cycle.
REQ-009 SHALL have port upg_rst_o  out  1  programmer reset; high means memory is in normal CPU mode.
REQ-010 SHALL have port upg_wen_o  out  1  instruction-memory write enable.
REQ-011 SHALL have port upg_adr_o  out  ADDR_W  instruction-memory word address.
REQ-012 SHALL have port upg_dat_o  out  32  instruction-memory write data.
REQ-013 SHALL have port upg_done_o  out  1  program load has completed.
REQ-014 SHALL have port cpu_hold  out  1  holds the CPU PC in reset while high.
REQ-015 SHALL have port err  out  1  sticky load error (size or timeout).

Function
REQ-016 SHALL implement the states IDLE, HDR0, HDR1, DATA, WRITE, DONE and ERR.
REQ-017 SHALL count a byte as transferred only in a cycle where both rx_valid and rx_ready are high.
REQ-018 SHALL drive rx_ready high only in HDR0, HDR1 and DATA.
REQ-019 SHALL, on start in IDLE, DONE or ERR, go to HDR0, clear err, upg_done_o, the word index and the byte index; start SHALL be ignored in any other state.
REQ-020 SHALL take the word count N from two header bytes, little-endian: HDR0 takes bits 7:0, HDR1 takes bits 15:8.
REQ-021 SHALL, on the HDR1 transfer, go to DONE if N==0, go to ERR if N>2^ADDR_W, and otherwise go to DATA.
REQ-022 SHALL assemble each word in DATA from 4 bytes, little-endian, with the first byte in bits 7:0.
REQ-023 SHALL, on the 4th byte transfer, go to WRITE on the next edge.
REQ-024 SHALL, in WRITE, assert upg_wen_o for exactly 1 cycle, with upg_adr_o equal to the word index and upg_dat_o equal to the assembled word.
REQ-025 SHALL, on leaving WRITE, increment the word index and go to DONE if the incremented index equals N, otherwise go to DATA; this gives a 1-cycle bubble per word.
REQ-026 SHALL have a latency of 1 cycle from the 4th byte transfer to the upg_wen_o pulse.
REQ-027 SHALL use an idle counter that clears on every transfer or state entry and counts in HDR0/HDR1/DATA while there is no transfer.
REQ-028 SHALL go to ERR when the idle counter reaches TIMEOUT_CYC-1 with no transfer in that cycle.
REQ-029 SHALL, when a transfer and the timeout fall in the same cycle, give the transfer priority, so no error occurs.
REQ-030 SHALL drive upg_rst_o as follows: 0 in HDR0/HDR1/DATA/WRITE/DONE; 1 in IDLE/ERR.
REQ-031 SHALL drive upg_done_o as 1 only in DONE, so the memory is back in normal mode in DONE and ERR.
REQ-032 SHALL drive cpu_hold as 1 in HDR0 through WRITE and in ERR; 0 in IDLE and DONE.
REQ-033 SHALL set err on entry to ERR and hold it until the next accepted start.
REQ-034 SHALL drive upg_wen_o as 0 in every state other than WRITE.
REQ-035 SHALL drive upg_adr_o and upg_dat_o from registers that are held between writes.
REQ-036 SHALL compute the word index with ADDR_W+1 bits so that N=2^ADDR_W terminates without wrap-around.

Reset
REQ-037 SHALL, while reset is high, asynchronously force: state=IDLE, upg_rst_o=1, upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, cpu_hold=0, rx_ready=0, err=0, and all counters to 0.
REQ-038 SHALL, when reset is asserted mid-load (including during WRITE), suppress the pending write immediately and never resume the load.

Structure
REQ-039 SHALL place the state encoding and the header byte count (2) and bytes-per-word (4) constants in the shared defines include.
REQ-040 SHALL contain one natural sub-module, prog_load_timeout: a loadable idle counter with clear, enable and expire ports.

Verification
REQ-041 SHALL verify that start followed by bytes 02 00 13 00 00 00 37 00 00 00 gives writes adr0=0x00000013 and adr1=0x00000037, after which the block reaches DONE with upg_done_o=1 and cpu_hold=0.
REQ-042 SHALL verify that header 00 00 gives DONE the cycle after the HDR1 transfer, with no upg_wen_o pulse.
REQ-043 SHALL verify, with ADDR_W=14, that header 01 40 (N=16385) gives ERR with err=1, upg_rst_o=1 and cpu_hold=1.
REQ-044 SHALL verify, with TIMEOUT_CYC=8, that sending 3 data bytes and then holding rx_valid low gives ERR exactly 8 cycles after the last transfer.
REQ-045 SHALL verify that asserting reset in the cycle WRITE is entered gives upg_wen_o=0 immediately, state=IDLE, and all outputs at their reset values.
REQ-046 SHALL verify that holding rx_valid high continuously shows rx_ready=0 for exactly 1 cycle per word and no byte loss.

Source files
------------

// File: rtl/prog_load_ctrl_pkg.sv
// Shared types and constants for the UART program loader: FSM state encoding
// and the header / word framing sizes.
package prog_load_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // States in which the loader is waiting for UART bytes.
  function automatic logic is_rx_state(input state_t s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/prog_load_timeout.sv
// Idle counter for the loader: clears on request, counts while enabled and
// flags expiry in the cycle the count reaches TIMEOUT_CYC-1.
module prog_load_timeout #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire = enable && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_load_ctrl.sv
// UART program loader: takes a 16-bit little-endian word count followed by
// 32-bit little-endian words and writes them into instruction memory.
module prog_load_ctrl
  import prog_load_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              upg_rst_o,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              cpu_hold,
  output logic              err
);

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              err_q, err_d;
  logic              rx_ready_q, rx_ready_d;
  logic              upg_rst_q, upg_rst_d;
  logic              wen_q, wen_d;
  logic              done_q, done_d;
  logic              hold_q, hold_d;
  logic [15:0]       n_full;
  logic              xfer;
  logic              idle_clear;
  logic              idle_enable;
  logic              idle_expire;

  assign xfer        = rx_valid && rx_ready_q;
  assign idle_enable = is_rx_state(state_q) && !xfer;
  assign idle_clear  = xfer || (state_d != state_q);

  prog_load_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .clear (idle_clear),
    .enable(idle_enable),
    .expire(idle_expire)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    err_d      = err_q;
    n_full     = {rx_data, n_q[7:0]};

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_HDR0;
          err_d      = 1'b0;
          word_idx_d = '0;
          byte_idx_d = '0;
        end
      end
      ST_HDR0: begin
        if (xfer) begin
          n_d[7:0] = rx_data;
          state_d  = ST_HDR1;
        end else if (idle_expire) begin
          state_d = ST_ERR;
        end
      end
      ST_HDR1: begin
        if (xfer) begin
          n_d[15:8] = rx_data;
          if (n_full == 16'd0) begin
            state_d = ST_DONE;
          end else if ({16'd0, n_full} > MAX_WORDS) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end else if (idle_expire) begin
          state_d = ST_ERR;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
            state_d = ST_WRITE;
            adr_d   = word_idx_q[ADDR_W-1:0];
            dat_d   = word_d;
          end
        end else if (idle_expire) begin
          state_d = ST_ERR;
        end
      end
      ST_WRITE: begin
        word_idx_d = word_idx_q + 1'b1;
        if (32'(word_idx_d) == 32'(n_q)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
      err_d = 1'b1;
    end
  end

  // Outputs are registered from the next state so they change with the state.
  always_comb begin
    rx_ready_d = is_rx_state(state_d);
    upg_rst_d  = (state_d == ST_IDLE) || (state_d == ST_ERR);
    wen_d      = (state_d == ST_WRITE);
    done_d     = (state_d == ST_DONE);
    hold_d     = is_rx_state(state_d) || (state_d == ST_WRITE) || (state_d == ST_ERR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      err_q      <= 1'b0;
      rx_ready_q <= 1'b0;
      upg_rst_q  <= 1'b1;
      wen_q      <= 1'b0;
      done_q     <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      err_q      <= err_d;
      rx_ready_q <= rx_ready_d;
      upg_rst_q  <= upg_rst_d;
      wen_q      <= wen_d;
      done_q     <= done_d;
      hold_q     <= hold_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign upg_rst_o  = upg_rst_q;
  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign cpu_hold   = hold_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Scoreboard bench for prog_load_ctrl: expected memory writes are queued as
// bytes are issued and a negedge monitor compares every upg_wen_o pulse.
module tb_prog_load_ctrl;

  localparam int AW = 14;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          upg_rst_o;
  logic          upg_wen_o;
  logic [AW-1:0] upg_adr_o;
  logic [31:0]   upg_dat_o;
  logic          upg_done_o;
  logic          cpu_hold;
  logic          err;

  typedef struct {
    logic [AW-1:0] adr;
    logic [31:0]   dat;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  total = 0;
  int  bad   = 0;
  int  low_cnt = 0;
  bit  low_en = 1'b0;

  prog_load_ctrl #(
    .ADDR_W(AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .upg_rst_o (upg_rst_o),
    .upg_wen_o (upg_wen_o),
    .upg_adr_o (upg_adr_o),
    .upg_dat_o (upg_dat_o),
    .upg_done_o(upg_done_o),
    .cpu_hold  (cpu_hold),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clock) begin
    if (low_en && !rx_ready && cpu_hold) low_cnt++;
    if (upg_wen_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: adr=0x%0h dat=0x%0h, expected no write", upg_adr_o, upg_dat_o);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_adr", 32'(upg_adr_o), 32'(mon_e.adr));
        checkOutput("wr_dat", upg_dat_o, mon_e.dat);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns 1 ns after the edge on which the byte was accepted.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      tick();
    end else begin
      total++;
      bad++;
      $display("[TB] FAIL handshake_timeout: byte 0x%0h not accepted, expected rx_ready within 40 cycles", b);
      rx_valid = 1'b0;
    end
  endtask

  function automatic int pickGap(input int mode);
    if (mode == 0) return 0;
    if ($urandom_range(0, 7) == 0) return TO - 1;
    return int'($urandom_range(0, 2));
  endfunction

  // Reference model: header is N little-endian, then N words of 4 LE bytes.
  task automatic runLoad(input int n, input int mode);
    logic [31:0] w;
    pulseStart();
    applyStimulus(8'(n), pickGap(mode));
    applyStimulus(8'(n >> 8), pickGap(mode));
    if (n != 0 && n <= (1 << AW)) begin
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        exp_q.push_back('{adr: AW'(i), dat: w});
        for (int b = 0; b < 4; b++) applyStimulus(w[8*b +: 8], pickGap(mode));
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    for (int k = 0; k < 50; k++) begin
      if (upg_done_o) break;
      tick();
    end
    checkOutput({tag, "_done"}, 32'(upg_done_o), 32'd1);
    checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_upg_rst"}, 32'(upg_rst_o), 32'd0);
  endtask

  task automatic checkResetVals(input string tag);
    checkOutput({tag, "_upg_rst"}, 32'(upg_rst_o), 32'd1);
    checkOutput({tag, "_wen"}, 32'(upg_wen_o), 32'd0);
    checkOutput({tag, "_adr"}, 32'(upg_adr_o), 32'd0);
    checkOutput({tag, "_dat"}, upg_dat_o, 32'd0);
    checkOutput({tag, "_done"}, 32'(upg_done_o), 32'd0);
    checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    checkOutput({tag, "_ready"}, 32'(rx_ready), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
  endtask

  logic [7:0] t1 [10];
  int         cyc;
  int         n;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    checkResetVals("reset");
    reset = 1'b0;
    tick();

    $display("[TB] two-word directed load");
    t1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h00, 8'h00, 8'h00};
    exp_q.push_back('{adr: AW'(0), dat: 32'h0000_0013});
    exp_q.push_back('{adr: AW'(1), dat: 32'h0000_0037});
    low_cnt = 0;
    pulseStart();
    checkOutput("hdr0_ready", 32'(rx_ready), 32'd1);
    low_en = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(t1[i], 0);
    rx_valid = 1'b0;
    waitDone("load2");
    low_en = 1'b0;
    checkOutput("load2_ready_low", 32'(low_cnt), 32'd2);
    checkOutput("held_adr", 32'(upg_adr_o), 32'd1);
    checkOutput("held_dat", upg_dat_o, 32'h0000_0037);

    $display("[TB] empty header");
    pulseStart();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    rx_valid = 1'b0;
    checkOutput("n0_done", 32'(upg_done_o), 32'd1);
    checkOutput("n0_hold", 32'(cpu_hold), 32'd0);
    repeat (3) tick();

    $display("[TB] oversize header");
    pulseStart();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h40, 0);
    rx_valid = 1'b0;
    checkOutput("big_err", 32'(err), 32'd1);
    checkOutput("big_upg_rst", 32'(upg_rst_o), 32'd1);
    checkOutput("big_hold", 32'(cpu_hold), 32'd1);
    checkOutput("big_done", 32'(upg_done_o), 32'd0);
    checkOutput("big_ready", 32'(rx_ready), 32'd0);

    $display("[TB] idle timeout");
    pulseStart();
    checkOutput("start_clears_err", 32'(err), 32'd0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    for (int b = 0; b < 3; b++) applyStimulus(8'(b + 8'hA0), 0);
    rx_valid = 1'b0;
    cyc = 0;
    while (cyc < 20 && !err) begin
      tick();
      cyc++;
    end
    checkOutput("timeout_cycles", 32'(cyc), 32'(TO));
    checkOutput("timeout_hold", 32'(cpu_hold), 32'd1);
    checkOutput("timeout_upg_rst", 32'(upg_rst_o), 32'd1);

    $display("[TB] transfer on the expiry cycle");
    exp_q.push_back('{adr: AW'(0), dat: 32'hCAFE_F00D});
    pulseStart();
    applyStimulus(8'h01, TO - 1);
    applyStimulus(8'h00, TO - 1);
    applyStimulus(8'h0D, TO - 1);
    applyStimulus(8'hF0, TO - 1);
    applyStimulus(8'hFE, TO - 1);
    applyStimulus(8'hCA, TO - 1);
    rx_valid = 1'b0;
    waitDone("edge");

    $display("[TB] reset on write entry");
    pulseStart();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    for (int b = 0; b < 4; b++) applyStimulus(8'h55, 0);
    rx_valid = 1'b0;
    checkOutput("wen_before_rst", 32'(upg_wen_o), 32'd1);
    reset = 1'b1;
    #1;
    checkResetVals("midrst");
    tick();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    checkOutput("no_resume_ready", 32'(rx_ready), 32'd0);
    checkOutput("no_resume_hold", 32'(cpu_hold), 32'd0);
    checkOutput("no_resume_upg_rst", 32'(upg_rst_o), 32'd1);

    $display("[TB] random loads");
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 6));
      low_cnt = 0;
      low_en  = (r < 2);
      runLoad(n, (r < 2) ? 0 : 1);
      waitDone("rand");
      if (r < 2) checkOutput("stream_ready_low", 32'(low_cnt), 32'(n));
      low_en = 1'b0;
      repeat ($urandom_range(1, 4)) tick();
    end

    repeat (3) tick();
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
